dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Word-addressed data-memory responder for the pipelined CPU's MEM stage.
//   - Accepts one load/store request at a time over a req/ready handshake.
//   - Inserts a programmable number of wait states before responding.
//   - busy_o drives the hazard unit, which stalls the pipeline while an access is in flight.
//   - Flags misaligned and out-of-range accesses with err_o instead of touching the storage.
// PARAMETERS
//   DEPTH        128  number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH-1
//   WAIT_CYCLES  2    wait states between acceptance and response (0 is legal)
// PORTS
//   clk_i    in   1   clock; all state updates on the rising edge
//   rst_n    in   1   synchronous, ACTIVE-HIGH reset (1 = reset); sampled on clk_i rising edge
//   req_i    in   1   request strobe from the CPU MEM stage
//   we_i     in   1   1 = store, 0 = load; sampled with req_i
//   addr_i   in   32  byte address; sampled with req_i
//   wdata_i  in   32  store data; sampled with req_i
//   rdata_o  out  32  load data; valid while ready_o=1 and err_o=0
//   ready_o  out  1   one-cycle response pulse
//   err_o    out  1   qualifies ready_o: 1 = access rejected
//   busy_o   out  1   1 while a request is held (stall request to the hazard unit)
// BEHAVIOUR
//   Reset state: state=IDLE, rdata_o=0, ready_o=0, err_o=0, busy_o=0, wait counter=0.
//   - Memory array contents are NOT reset.
//   - Reset asserted mid-transaction aborts it: no write is committed and no ready_o pulse follows.
//   FSM states: IDLE, WAIT, RESP.
//   IDLE: if req_i=1, capture we_i, addr_i and wdata_i.
//     - Bad access (addr_i[1:0]!=0 or addr_i>=4*DEPTH): go to RESP with err flag set.
//     - Otherwise, if WAIT_CYCLES=0: go directly to RESP.
//     - Otherwise: load counter=WAIT_CYCLES-1 and go to WAIT.
//   WAIT: decrement the counter each cycle; when counter=0, go to RESP.
//     - req_i, we_i, addr_i and wdata_i are ignored in WAIT.
//   Commit on the edge entering RESP (good access only):
//     - store: mem[addr>>2] <= wdata.
//     - load: rdata_o <= mem[addr>>2].
//   RESP: ready_o=1 for exactly one cycle; err_o=1 only for a bad access; next state is IDLE.
//     - A req_i asserted during RESP is not accepted; it is accepted the following IDLE cycle.
//   Bad access: the memory is unchanged, rdata_o holds its previous value, and no wait states are inserted.
//   Latency: ready_o rises WAIT_CYCLES+1 cycles after the accepting edge (1 cycle for a bad access).
//   busy_o=1 in WAIT and RESP; busy_o=0 in IDLE (combinational from state).
//   Throughput: at most one transaction per WAIT_CYCLES+2 cycles.
//   Ordering: a load issued after a store to the same word returns the stored value.
//   Address index uses addr[log2(DEPTH)+1:2]; the upper bits are only used for the range check.
// TESTING
//   1. Reset: hold rst_n=1 for 2 cycles -> rdata_o=0, ready_o=0, err_o=0, busy_o=0.
//   2. Store then load: store 0xDEADBEEF to 0x10, then load 0x10 (WAIT_CYCLES=2)
//      -> ready_o 3 cycles after each accept; load rdata_o=0xDEADBEEF, err_o=0.
//   3. Misaligned load at 0x13 -> ready_o=1, err_o=1 the next cycle; memory unchanged;
//      rdata_o unchanged; busy_o high for 1 cycle.
//   4. Out of range: store to 0x200 with DEPTH=128 -> err_o=1; a subsequent load of 0x1FC
//      returns its old value.
//   5. Change addr_i/wdata_i during WAIT, and hold req_i high through RESP
//      -> the original captured request completes; the second request is accepted only in IDLE.
//   6. Reset pulse in WAIT of a store to 0x20 -> no ready_o; a load of 0x20 returns the pre-store value.
//      Repeat tests 2-6 with WAIT_CYCLES=0 (latency 1).

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory for the CPU MEM stage.
// Serves one load/store at a time and inserts WAIT_CYCLES wait states
// before a one-cycle ready_o pulse. Misaligned or out-of-range accesses
// are answered immediately with err_o and never touch the storage.
// Note: rst_n is active-HIGH (1 = reset) despite its name.
module dmem_responder #(
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ready_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [32:0]      ADDR_LIMIT = 33'(4 * DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cap_we;
    logic [IDX_W-1:0] cap_idx;
    logic [31:0]      cap_wdata;

    logic [31:0]      mem [DEPTH];

    logic             bad_req;
    logic [IDX_W-1:0] req_idx;
    logic             go_direct;
    logic             go_wait_done;
    logic             commit;
    logic             commit_we;
    logic [IDX_W-1:0] commit_idx;
    logic [31:0]      commit_wdata;

    // Decode the incoming request and select which request commits this edge.
    always_comb begin
        bad_req      = (addr_i[1:0] != 2'b00) || ({1'b0, addr_i} >= ADDR_LIMIT);
        req_idx      = addr_i[IDX_W+1:2];
        go_direct    = (state == S_IDLE) && req_i && !bad_req && (WAIT_CYCLES == 0);
        go_wait_done = (state == S_WAIT) && (cnt == '0);
        commit       = !rst_n && (go_direct || go_wait_done);
        commit_we    = go_direct ? we_i    : cap_we;
        commit_idx   = go_direct ? req_idx : cap_idx;
        commit_wdata = go_direct ? wdata_i : cap_wdata;
        busy_o       = (state != S_IDLE);
    end

    // Storage write port; contents are deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (commit && commit_we) begin
            mem[commit_idx] <= commit_wdata;
        end
    end

    // Request FSM with registered response outputs and load data.
    always_ff @(posedge clk_i) begin
        if (rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rdata_o   <= '0;
            ready_o   <= 1'b0;
            err_o     <= 1'b0;
            cap_we    <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready_o <= 1'b0;
                    err_o   <= 1'b0;
                    if (req_i) begin
                        cap_we    <= we_i;
                        cap_idx   <= req_idx;
                        cap_wdata <= wdata_i;
                        if (bad_req) begin
                            state   <= S_RESP;
                            ready_o <= 1'b1;
                            err_o   <= 1'b1;
                        end else if (WAIT_CYCLES == 0) begin
                            state   <= S_RESP;
                            ready_o <= 1'b1;
                        end else begin
                            cnt   <= CNT_LOAD;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state   <= S_RESP;
                        ready_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    state   <= S_IDLE;
                    ready_o <= 1'b0;
                    err_o   <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    ready_o <= 1'b0;
                    err_o   <= 1'b0;
                end
            endcase
            if (commit && !commit_we) begin
                rdata_o <= mem[commit_idx];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 uses WAIT_CYCLES=2,
// instance 1 uses WAIT_CYCLES=0; every scenario runs on both.
module tb_dmem_responder;

    logic        clk;
    logic        rst   [2];
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        err   [2];
    logic        busy  [2];

    int tests_run    = 0;
    int tests_failed = 0;

    dmem_responder #(.DEPTH(128), .WAIT_CYCLES(2)) dut_w2 (
        .clk_i(clk), .rst_n(rst[0]), .req_i(req[0]), .we_i(we[0]),
        .addr_i(addr[0]), .wdata_i(wdata[0]), .rdata_o(rdata[0]),
        .ready_o(ready[0]), .err_o(err[0]), .busy_o(busy[0])
    );

    dmem_responder #(.DEPTH(128), .WAIT_CYCLES(0)) dut_w0 (
        .clk_i(clk), .rst_n(rst[1]), .req_i(req[1]), .we_i(we[1]),
        .addr_i(addr[1]), .wdata_i(wdata[1]), .rdata_o(rdata[1]),
        .ready_o(ready[1]), .err_o(err[1]), .busy_o(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wc(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One single-cycle request; returns latency (cycles after accepting edge),
    // err and rdata seen with ready, then steps back into IDLE.
    task automatic do_access(input int d, input logic w, input logic [31:0] a,
                             input logic [31:0] wd, output int lat,
                             output logic e, output logic [31:0] rd);
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        tick();
        req[d] = 1'b0;
        lat = 1;
        while (ready[d] !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        e  = err[d];
        rd = rdata[d];
        tick();
    endtask

    task automatic test_reset(input int d);
        rst[d] = 1'b1; req[d] = 1'b0;
        tick(); tick();
        tests_run++; if (rdata[d] !== 32'h0) begin tests_failed++; $display("FAIL d%0d reset_rdata got=%h exp=%h", d, rdata[d], 32'h0); end
        tests_run++; if (ready[d] !== 1'b0) begin tests_failed++; $display("FAIL d%0d reset_ready got=%b exp=0", d, ready[d]); end
        tests_run++; if (err[d] !== 1'b0) begin tests_failed++; $display("FAIL d%0d reset_err got=%b exp=0", d, err[d]); end
        tests_run++; if (busy[d] !== 1'b0) begin tests_failed++; $display("FAIL d%0d reset_busy got=%b exp=0", d, busy[d]); end
        rst[d] = 1'b0;
    endtask

    task automatic test_store_load(input int d);
        int lat; logic e; logic [31:0] rd;
        do_access(d, 1'b1, 32'h10, 32'hDEADBEEF, lat, e, rd);
        tests_run++; if (lat != wc(d) + 1) begin tests_failed++; $display("FAIL d%0d store_latency got=%0d exp=%0d", d, lat, wc(d) + 1); end
        tests_run++; if (e !== 1'b0) begin tests_failed++; $display("FAIL d%0d store_err got=%b exp=0", d, e); end
        do_access(d, 1'b0, 32'h10, 32'h0, lat, e, rd);
        tests_run++; if (lat != wc(d) + 1) begin tests_failed++; $display("FAIL d%0d load_latency got=%0d exp=%0d", d, lat, wc(d) + 1); end
        tests_run++; if (e !== 1'b0) begin tests_failed++; $display("FAIL d%0d load_err got=%b exp=0", d, e); end
        tests_run++; if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL d%0d load_rdata got=%h exp=%h", d, rd, 32'hDEADBEEF); end
    endtask

    task automatic test_misaligned(input int d);
        int lat; logic e; logic [31:0] rd;
        req[d] = 1'b1; we[d] = 1'b0; addr[d] = 32'h13; wdata[d] = 32'h0;
        tick();
        req[d] = 1'b0;
        tests_run++; if (ready[d] !== 1'b1) begin tests_failed++; $display("FAIL d%0d misal_ready got=%b exp=1", d, ready[d]); end
        tests_run++; if (err[d] !== 1'b1) begin tests_failed++; $display("FAIL d%0d misal_err got=%b exp=1", d, err[d]); end
        tests_run++; if (busy[d] !== 1'b1) begin tests_failed++; $display("FAIL d%0d misal_busy got=%b exp=1", d, busy[d]); end
        tests_run++; if (rdata[d] !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL d%0d misal_rdata_held got=%h exp=%h", d, rdata[d], 32'hDEADBEEF); end
        tick();
        tests_run++; if (ready[d] !== 1'b0) begin tests_failed++; $display("FAIL d%0d misal_ready_drop got=%b exp=0", d, ready[d]); end
        tests_run++; if (busy[d] !== 1'b0) begin tests_failed++; $display("FAIL d%0d misal_busy_drop got=%b exp=0", d, busy[d]); end
        // Misaligned store whose word index aliases 0x10 must not write.
        do_access(d, 1'b1, 32'h13, 32'h11111111, lat, e, rd);
        tests_run++; if (e !== 1'b1 || lat != 1) begin tests_failed++; $display("FAIL d%0d misal_store got err=%b lat=%0d exp err=1 lat=1", d, e, lat); end
        do_access(d, 1'b0, 32'h10, 32'h0, lat, e, rd);
        tests_run++; if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL d%0d misal_mem_kept got=%h exp=%h", d, rd, 32'hDEADBEEF); end
    endtask

    task automatic test_out_of_range(input int d);
        int lat; logic e; logic [31:0] rd;
        do_access(d, 1'b1, 32'h1FC, 32'hCAFEF00D, lat, e, rd);
        do_access(d, 1'b1, 32'h0, 32'hA5A5A5A5, lat, e, rd);
        do_access(d, 1'b1, 32'h200, 32'h12345678, lat, e, rd);
        tests_run++; if (e !== 1'b1) begin tests_failed++; $display("FAIL d%0d oor_err got=%b exp=1", d, e); end
        tests_run++; if (lat != 1) begin tests_failed++; $display("FAIL d%0d oor_latency got=%0d exp=1", d, lat); end
        do_access(d, 1'b0, 32'h1FC, 32'h0, lat, e, rd);
        tests_run++; if (rd !== 32'hCAFEF00D || e !== 1'b0) begin tests_failed++; $display("FAIL d%0d oor_1fc got=%h err=%b exp=%h err=0", d, rd, e, 32'hCAFEF00D); end
        do_access(d, 1'b0, 32'h0, 32'h0, lat, e, rd);
        tests_run++; if (rd !== 32'hA5A5A5A5) begin tests_failed++; $display("FAIL d%0d oor_alias0 got=%h exp=%h", d, rd, 32'hA5A5A5A5); end
    endtask

    task automatic test_hold_req(input int d);
        int lat; logic e; logic [31:0] rd;
        req[d] = 1'b1; we[d] = 1'b1; addr[d] = 32'h40; wdata[d] = 32'h01020304;
        tick();
        addr[d] = 32'h44; wdata[d] = 32'hFFFFFFFF;
        lat = 1;
        while (ready[d] !== 1'b1 && lat < 20) begin tick(); lat++; end
        tests_run++; if (lat != wc(d) + 1) begin tests_failed++; $display("FAIL d%0d hold_latency got=%0d exp=%0d", d, lat, wc(d) + 1); end
        tick();
        tests_run++; if (busy[d] !== 1'b0 || ready[d] !== 1'b0) begin tests_failed++; $display("FAIL d%0d hold_resp_not_accepted got busy=%b ready=%b exp 0 0", d, busy[d], ready[d]); end
        tick();
        tests_run++; if (busy[d] !== 1'b1) begin tests_failed++; $display("FAIL d%0d hold_idle_accept got busy=%b exp=1", d, busy[d]); end
        req[d] = 1'b0;
        lat = 1;
        while (ready[d] !== 1'b1 && lat < 20) begin tick(); lat++; end
        tests_run++; if (lat != wc(d) + 1) begin tests_failed++; $display("FAIL d%0d hold_second_latency got=%0d exp=%0d", d, lat, wc(d) + 1); end
        tick();
        do_access(d, 1'b0, 32'h40, 32'h0, lat, e, rd);
        tests_run++; if (rd !== 32'h01020304) begin tests_failed++; $display("FAIL d%0d hold_first_data got=%h exp=%h", d, rd, 32'h01020304); end
        do_access(d, 1'b0, 32'h44, 32'h0, lat, e, rd);
        tests_run++; if (rd !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL d%0d hold_second_data got=%h exp=%h", d, rd, 32'hFFFFFFFF); end
    endtask

    task automatic test_reset_abort(input int d);
        int lat; int pulses; logic e; logic [31:0] rd;
        do_access(d, 1'b1, 32'h20, 32'h0BADF00D, lat, e, rd);
        req[d] = 1'b1; we[d] = 1'b1; addr[d] = 32'h20; wdata[d] = 32'h77777777;
        if (wc(d) != 0) begin
            tick();
            req[d] = 1'b0;
        end
        rst[d] = 1'b1;
        tick();
        req[d] = 1'b0; rst[d] = 1'b0;
        tests_run++; if (busy[d] !== 1'b0 || rdata[d] !== 32'h0) begin tests_failed++; $display("FAIL d%0d abort_state got busy=%b rdata=%h exp 0 0", d, busy[d], rdata[d]); end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (ready[d] === 1'b1) pulses++;
            tick();
        end
        tests_run++; if (pulses != 0) begin tests_failed++; $display("FAIL d%0d abort_no_ready got=%0d pulses exp=0", d, pulses); end
        do_access(d, 1'b0, 32'h20, 32'h0, lat, e, rd);
        tests_run++; if (rd !== 32'h0BADF00D) begin tests_failed++; $display("FAIL d%0d abort_no_write got=%h exp=%h", d, rd, 32'h0BADF00D); end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0;
            addr[i] = 32'h0; wdata[i] = 32'h0;
        end
        for (int d = 0; d < 2; d++) begin
            test_reset(d);
            test_store_load(d);
            test_misaligned(d);
            test_out_of_range(d);
            test_hold_req(d);
            test_reset_abort(d);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
